// File: rtl/traceback_alignment_writer.sv
// ---------------------------------------------------------------------------
// traceback_alignment_writer
//
// Sits behind the traceback direction counter. For every traceback step it
// fetches the sequence A/B bases at the step coordinates and builds one
// aligned column (base/base, base/gap or gap/base). Traceback walks from the
// end of the alignment back to the start, so columns go into a LIFO. Once
// end_c arrives, the LIFO is drained and the columns come out in forward
// order over a valid/ready handshake.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   en_traceB           traceback enable; dropping it aborts to IDLE
//   step_valid          one-cycle step strobe (symbol, i_t_ram, j_t_ram valid)
//   symbol              UP=3'b010, LEFT=3'b100, DIAG=3'b001
//   end_c               traceback reached (0,0); starts the readout
//   i_t_ram, j_t_ram    seq A / seq B coordinates of the step
//   addr_a, addr_b      sequence ROM addresses (registered)
//   char_a, char_b      ROM data, valid one cycle after the address
//   out_valid/out_ready output column handshake
//   out_a, out_b        aligned characters, 0..3 = base, 3'b100 = gap
//   out_last            marks the final column
//   align_len           number of columns stored for this alignment
//   done                every column has been delivered
//   err                 sticky: a step or a push was dropped
// ---------------------------------------------------------------------------
module traceback_alignment_writer #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1),
    parameter int DEPTH   = 2 * N,
    parameter int PtrW    = $clog2(2 * N + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_traceB,
    input  logic               step_valid,
    input  logic [2:0]         symbol,
    input  logic               end_c,
    input  logic [BitAddr:0]   i_t_ram,
    input  logic [BitAddr:0]   j_t_ram,
    output logic [BitAddr:0]   addr_a,
    output logic [BitAddr:0]   addr_b,
    input  logic [1:0]         char_a,
    input  logic [1:0]         char_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_a,
    output logic [2:0]         out_b,
    output logic               out_last,
    output logic [PtrW-1:0]    align_len,
    output logic               done,
    output logic               err
);

    localparam int              AddrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0] DEPTH_P  = PtrW'(DEPTH);
    localparam logic [2:0]      SYM_DIAG = 3'b001;
    localparam logic [2:0]      SYM_UP   = 3'b010;
    localparam logic [2:0]      SYM_LEFT = 3'b100;
    localparam logic [2:0]      GAP      = 3'b100;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, FLUSH, DONE} state_t;

    state_t           state_reg;
    logic [PtrW-1:0]  ptr_reg;
    logic [2:0]       sym_reg;
    logic [BitAddr:0] i_reg;
    logic [BitAddr:0] j_reg;

    // LIFO storage: {a[2:0], b[2:0]} per column
    logic [5:0]       mem [0:DEPTH-1];

    logic             push_req;
    logic [5:0]       push_data;
    logic             push_en;
    logic [PtrW-1:0]  rd_ptr;
    logic [AddrW-1:0] rd_addr;
    logic [AddrW-1:0] wr_addr;

    always_comb begin
        push_req  = 1'b1;
        push_data = {1'b0, char_a, 1'b0, char_b};
        case (sym_reg)
            SYM_DIAG: push_data = {1'b0, char_a, 1'b0, char_b};
            SYM_UP:   push_data = {1'b0, char_a, GAP};
            SYM_LEFT: push_data = {GAP, 1'b0, char_b};
            default:  push_req  = 1'b0;
        endcase
    end

    // A push into a full LIFO is discarded rather than wrapping.
    assign push_en = (state_reg == WRITE) && en_traceB && push_req && (ptr_reg != DEPTH_P);
    assign wr_addr = ptr_reg[AddrW-1:0];

    // Entering FLUSH presents the top entry (ptr-1); each transfer inside FLUSH
    // preloads the entry below it (ptr-2) so the next column is ready at once.
    assign rd_ptr  = (state_reg == FLUSH) ? ptr_reg - PtrW'(2) : ptr_reg - PtrW'(1);
    assign rd_addr = rd_ptr[AddrW-1:0];

    generate
        if (PtrW > AddrW) begin : g_rd_hi
            logic unused_rd_hi;
            assign unused_rd_hi = ^rd_ptr[PtrW-1:AddrW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_addr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            sym_reg   <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            addr_a    <= '0;
            addr_b    <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_last  <= 1'b0;
            align_len <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Upstream is only allowed to strobe a step while we are idle.
            if (step_valid && (state_reg != IDLE)) begin
                err <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (!en_traceB) begin
                        ptr_reg   <= '0;
                        align_len <= '0;
                    end else if (step_valid) begin
                        sym_reg   <= symbol;
                        i_reg     <= i_t_ram;
                        j_reg     <= j_t_ram;
                        state_reg <= FETCH;
                    end else if (end_c) begin
                        if (ptr_reg == '0) begin
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            out_a     <= mem[rd_addr][5:3];
                            out_b     <= mem[rd_addr][2:0];
                            out_valid <= 1'b1;
                            out_last  <= (ptr_reg == PtrW'(1));
                            state_reg <= FLUSH;
                        end
                    end
                end

                FETCH, WAIT, WRITE: begin
                    if (!en_traceB) begin
                        ptr_reg   <= '0;
                        align_len <= '0;
                        state_reg <= IDLE;
                    end else if (state_reg == FETCH) begin
                        addr_a    <= i_reg;
                        addr_b    <= j_reg;
                        state_reg <= WAIT;
                    end else if (state_reg == WAIT) begin
                        state_reg <= WRITE;
                    end else begin
                        if (push_req) begin
                            if (ptr_reg == DEPTH_P) begin
                                err <= 1'b1;
                            end else begin
                                ptr_reg   <= ptr_reg + PtrW'(1);
                                align_len <= align_len + PtrW'(1);
                            end
                        end
                        state_reg <= IDLE;
                    end
                end

                FLUSH: begin
                    if (!en_traceB) begin
                        ptr_reg   <= '0;
                        align_len <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (out_ready) begin
                        if (ptr_reg == PtrW'(1)) begin
                            ptr_reg   <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            ptr_reg  <= ptr_reg - PtrW'(1);
                            out_a    <= mem[rd_addr][5:3];
                            out_b    <= mem[rd_addr][2:0];
                            out_last <= (ptr_reg == PtrW'(2));
                        end
                    end
                end

                DONE: begin
                    if (!en_traceB) begin
                        ptr_reg   <= '0;
                        align_len <= '0;
                        done      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_traceback_alignment_writer.sv
// ---------------------------------------------------------------------------
// Directed testbench for traceback_alignment_writer with N=4
// (coordinates 4 bits, LIFO depth 8, length width 4).
// ---------------------------------------------------------------------------
module tb_traceback_alignment_writer;

    localparam logic [2:0] DIAG = 3'b001;
    localparam logic [2:0] UP   = 3'b010;
    localparam logic [2:0] LEFT = 3'b100;
    localparam logic [2:0] GAP  = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_traceB;
    logic       step_valid;
    logic [2:0] symbol;
    logic       end_c;
    logic [3:0] i_t_ram;
    logic [3:0] j_t_ram;
    logic [3:0] addr_a;
    logic [3:0] addr_b;
    logic [1:0] char_a;
    logic [1:0] char_b;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_a;
    logic [2:0] out_b;
    logic       out_last;
    logic [3:0] align_len;
    logic       done;
    logic       err;

    logic [1:0] rom_a [0:15];
    logic [1:0] rom_b [0:15];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Sequence ROMs with one cycle of read latency
    always @(posedge clk) begin
        char_a <= rom_a[addr_a];
        char_b <= rom_b[addr_b];
    end

    traceback_alignment_writer #(.N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_traceB  (en_traceB),
        .step_valid (step_valid),
        .symbol     (symbol),
        .end_c      (end_c),
        .i_t_ram    (i_t_ram),
        .j_t_ram    (j_t_ram),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .char_a     (char_a),
        .char_b     (char_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_last   (out_last),
        .align_len  (align_len),
        .done       (done),
        .err        (err)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step_valid = 1'b0;
        end_c      = 1'b0;
        en_traceB  = 1'b0;
        out_ready  = 1'b0;
        symbol     = 3'b000;
        i_t_ram    = '0;
        j_t_ram    = '0;
        rst        = 1'b1;
        tick();
        rst        = 1'b0;
        en_traceB  = 1'b1;
        tick();
    endtask

    // One step with a 4-cycle period: strobe, then FETCH/WAIT/WRITE
    task automatic do_step(input logic [2:0] sym, input logic [3:0] i, input logic [3:0] j);
        step_valid = 1'b1;
        symbol     = sym;
        i_t_ram    = i;
        j_t_ram    = j;
        tick();
        step_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_end();
        end_c = 1'b1;
        tick();
        end_c = 1'b0;
    endtask

    task automatic end_run();
        en_traceB = 1'b0;
        tick();
        en_traceB = 1'b1;
        tick();
    endtask

    task automatic load_rom_ident();
        for (int k = 0; k < 16; k++) begin
            rom_a[k] = 2'(k);
            rom_b[k] = 2'(k);
        end
    endtask

    task automatic load_rom_mixed();
        logic [1:0] ta [0:3];
        logic [1:0] tb [0:3];
        ta = '{2'd2, 2'd3, 2'd1, 2'd0};
        tb = '{2'd1, 2'd0, 2'd3, 2'd2};
        for (int k = 0; k < 16; k++) begin
            rom_a[k] = ta[k % 4];
            rom_b[k] = tb[k % 4];
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({out_valid, out_last, done, err} !== 4'b0000) begin
            $display("FAIL reset_flags: valid/last/done/err=%b expected 0000", {out_valid, out_last, done, err});
            tests_failed++;
        end
        tests_run++;
        if ({align_len, addr_a, addr_b, out_a, out_b} !== 18'd0) begin
            $display("FAIL reset_values: len=%0d addr_a=%0d addr_b=%0d out_a=%0d out_b=%0d expected all 0",
                     align_len, addr_a, addr_b, out_a, out_b);
            tests_failed++;
        end
        load_rom_ident();
        do_step(DIAG, 4'd2, 4'd3);
        tests_run++;
        if (align_len !== 4'd1 || addr_a !== 4'd2 || addr_b !== 4'd3) begin
            $display("FAIL reset_pre_step: len=%0d addr_a=%0d addr_b=%0d expected 1 2 3", align_len, addr_a, addr_b);
            tests_failed++;
        end
        // Asynchronous: takes effect without a clock edge
        rst = 1'b1;
        #1;
        tests_run++;
        if (align_len !== 4'd0 || addr_a !== 4'd0) begin
            $display("FAIL reset_async: len=%0d addr_a=%0d expected 0 0", align_len, addr_a);
            tests_failed++;
        end
        rst = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_diag();
        do_reset();
        load_rom_ident();
        out_ready = 1'b1;
        for (int k = 3; k >= 0; k--) do_step(DIAG, 4'(k), 4'(k));
        tests_run++;
        if (align_len !== 4'd4) begin
            $display("FAIL diag_len: align_len=%0d expected 4", align_len);
            tests_failed++;
        end
        pulse_end();
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_a !== 3'(k) || out_b !== 3'(k) || out_last !== (k == 3)) begin
                $display("FAIL diag_col%0d: valid=%b a=%0d b=%0d last=%b expected 1 %0d %0d %b",
                         k, out_valid, out_a, out_b, out_last, k, k, (k == 3));
                tests_failed++;
            end
            $display("[TB] diag col %0d a=%0d b=%0d last=%b", k, out_a, out_b, out_last);
            tick();
        end
        tests_run++;
        if (out_valid !== 1'b0 || done !== 1'b1 || align_len !== 4'd4 || err !== 1'b0) begin
            $display("FAIL diag_done: valid=%b done=%b len=%0d err=%b expected 0 1 4 0", out_valid, done, align_len, err);
            tests_failed++;
        end
        en_traceB = 1'b0;
        tick();
        tests_run++;
        if (done !== 1'b0 || align_len !== 4'd0) begin
            $display("FAIL diag_idle: done=%b len=%0d expected 0 0", done, align_len);
            tests_failed++;
        end
        en_traceB = 1'b1;
        tick();
    endtask

    task automatic test_gaps();
        logic [2:0] ea [0:3];
        logic [2:0] eb [0:3];
        do_reset();
        load_rom_mixed();
        out_ready = 1'b1;
        // pushes: (0,GAP) (1,3) (GAP,0) (3,1)
        do_step(UP,   4'd3, 4'd2);
        do_step(DIAG, 4'd2, 4'd2);
        do_step(LEFT, 4'd1, 4'd1);
        do_step(DIAG, 4'd1, 4'd0);
        ea = '{3'd3, GAP,  3'd1, 3'd0};
        eb = '{3'd1, 3'd0, 3'd3, GAP};
        tests_run++;
        if (align_len !== 4'd4) begin
            $display("FAIL gaps_len: align_len=%0d expected 4", align_len);
            tests_failed++;
        end
        pulse_end();
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_a !== ea[k] || out_b !== eb[k] || out_last !== (k == 3)) begin
                $display("FAIL gaps_col%0d: valid=%b a=%0d b=%0d last=%b expected 1 %0d %0d %b",
                         k, out_valid, out_a, out_b, out_last, ea[k], eb[k], (k == 3));
                tests_failed++;
            end
            $display("[TB] gaps col %0d a=%0d b=%0d last=%b", k, out_a, out_b, out_last);
            tick();
        end
        tests_run++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL gaps_done: done=%b valid=%b expected 1 0", done, out_valid);
            tests_failed++;
        end
        end_run();
    endtask

    task automatic test_backpressure();
        logic [2:0] ea [0:3];
        logic [2:0] eb [0:3];
        logic       pat [0:7];
        int         idx;
        do_reset();
        load_rom_mixed();
        for (int k = 3; k >= 0; k--) do_step(DIAG, 4'(k), 4'(k));
        ea  = '{3'd2, 3'd3, 3'd1, 3'd0};
        eb  = '{3'd1, 3'd0, 3'd3, 3'd2};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        idx = 0;
        pulse_end();
        for (int c = 0; c < 8 && idx < 4; c++) begin
            out_ready = pat[c];
            tests_run++;
            if (out_valid !== 1'b1 || out_a !== ea[idx] || out_b !== eb[idx] || out_last !== (idx == 3)) begin
                $display("FAIL bp_cycle%0d: valid=%b a=%0d b=%0d last=%b expected 1 %0d %0d %b",
                         c, out_valid, out_a, out_b, out_last, ea[idx], eb[idx], (idx == 3));
                tests_failed++;
            end
            $display("[TB] bp cycle %0d ready=%b a=%0d b=%0d", c, out_ready, out_a, out_b);
            tick();
            if (pat[c]) idx++;
        end
        tests_run++;
        if (idx !== 4 || out_valid !== 1'b0 || done !== 1'b1) begin
            $display("FAIL bp_end: delivered=%0d valid=%b done=%b expected 4 0 1", idx, out_valid, done);
            tests_failed++;
        end
        out_ready = 1'b1;
        end_run();
    endtask

    task automatic test_drop_step();
        do_reset();
        load_rom_mixed();
        out_ready  = 1'b1;
        step_valid = 1'b1;
        symbol     = DIAG;
        i_t_ram    = 4'd1;
        j_t_ram    = 4'd1;
        tick();                 // now in FETCH
        symbol     = LEFT;      // second strobe must be ignored
        i_t_ram    = 4'd2;
        j_t_ram    = 4'd2;
        tick();
        step_valid = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (err !== 1'b1 || align_len !== 4'd1) begin
            $display("FAIL drop_step: err=%b len=%0d expected 1 1", err, align_len);
            tests_failed++;
        end
        pulse_end();
        tests_run++;
        if (out_valid !== 1'b1 || out_a !== 3'd3 || out_b !== 3'd0 || out_last !== 1'b1) begin
            $display("FAIL drop_col: valid=%b a=%0d b=%0d last=%b expected 1 3 0 1", out_valid, out_a, out_b, out_last);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (done !== 1'b1 || out_valid !== 1'b0 || err !== 1'b1) begin
            $display("FAIL drop_done: done=%b valid=%b err=%b expected 1 0 1", done, out_valid, err);
            tests_failed++;
        end
        end_run();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            rom_a[k] = 2'(k % 4);
            rom_b[k] = 2'((k + 1) % 4);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) do_step(DIAG, 4'(k), 4'(k));
        tests_run++;
        if (err !== 1'b0 || align_len !== 4'd8) begin
            $display("FAIL ovf_full: err=%b len=%0d expected 0 8", err, align_len);
            tests_failed++;
        end
        do_step(DIAG, 4'd8, 4'd8);
        tests_run++;
        if (err !== 1'b1 || align_len !== 4'd8) begin
            $display("FAIL ovf_drop: err=%b len=%0d expected 1 8", err, align_len);
            tests_failed++;
        end
        pulse_end();
        for (int k = 7; k >= 0; k--) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_a !== 3'(k % 4) || out_b !== 3'((k + 1) % 4) || out_last !== (k == 0)) begin
                $display("FAIL ovf_col%0d: valid=%b a=%0d b=%0d last=%b expected 1 %0d %0d %b",
                         k, out_valid, out_a, out_b, out_last, k % 4, (k + 1) % 4, (k == 0));
                tests_failed++;
            end
            $display("[TB] ovf col a=%0d b=%0d last=%b", out_a, out_b, out_last);
            tick();
        end
        tests_run++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL ovf_done: done=%b valid=%b expected 1 0", done, out_valid);
            tests_failed++;
        end
        end_run();
    endtask

    task automatic test_abort_restart();
        do_reset();
        load_rom_ident();
        out_ready = 1'b1;
        for (int k = 2; k >= 0; k--) do_step(DIAG, 4'(k), 4'(k));
        pulse_end();
        tests_run++;
        if (out_valid !== 1'b1 || out_a !== 3'd0 || out_b !== 3'd0) begin
            $display("FAIL abort_first: valid=%b a=%0d b=%0d expected 1 0 0", out_valid, out_a, out_b);
            tests_failed++;
        end
        tick();
        en_traceB = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || align_len !== 4'd0 || done !== 1'b0) begin
            $display("FAIL abort_idle: valid=%b len=%0d done=%b expected 0 0 0", out_valid, align_len, done);
            tests_failed++;
        end
        en_traceB = 1'b1;
        tick();
        do_step(DIAG, 4'd3, 4'd3);
        do_step(DIAG, 4'd1, 4'd1);
        tests_run++;
        if (align_len !== 4'd2) begin
            $display("FAIL restart_len: align_len=%0d expected 2", align_len);
            tests_failed++;
        end
        pulse_end();
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_a !== 3'(2 * k + 1) || out_b !== 3'(2 * k + 1) || out_last !== (k == 1)) begin
                $display("FAIL restart_col%0d: valid=%b a=%0d b=%0d last=%b expected 1 %0d %0d %b",
                         k, out_valid, out_a, out_b, out_last, 2 * k + 1, 2 * k + 1, (k == 1));
                tests_failed++;
            end
            $display("[TB] restart col %0d a=%0d b=%0d last=%b", k, out_a, out_b, out_last);
            tick();
        end
        tests_run++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL restart_done: done=%b valid=%b expected 1 0", done, out_valid);
            tests_failed++;
        end
        end_run();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            rom_a[k] = '0;
            rom_b[k] = '0;
        end
        rst        = 1'b1;
        en_traceB  = 1'b0;
        step_valid = 1'b0;
        end_c      = 1'b0;
        out_ready  = 1'b0;
        symbol     = 3'b000;
        i_t_ram    = '0;
        j_t_ram    = '0;
        test_reset();
        test_diag();
        test_gaps();
        test_backpressure();
        test_drop_step();
        test_overflow();
        test_abort_restart();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
